// File: rtl/vend_credit_ctrl.sv
// vend_credit_ctrl: ticket credit accumulation, dispense strobe and coin-by-coin change payout.
// Optional inactivity timeout in COLLECT is enabled by defining VEND_TIMEOUT_EN.
module vend_credit_ctrl #(
  parameter int CREDIT_MAX = 99
`ifdef VEND_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel_valid,
  input  logic [7:0] sel_price,
  input  logic       coin_valid,
  input  logic [7:0] coin_val,
  input  logic       cancel,
  output logic       coin_en,
  output logic [7:0] credit,
  output logic       reject,
  output logic       dispense,
  output logic       chg_valid,
  output logic [3:0] chg_coin,
  input  logic       chg_ack,
  output logic       busy
`ifdef VEND_TIMEOUT_EN
  , output logic     timeout
`endif
);
  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;
  state_t state;
  logic [7:0] price, den, new_credit;
  logic [8:0] sum;
  logic legal, acc, quit, tmo_hit;
`ifdef VEND_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] cnt;
  assign tmo_hit = cnt == CW'(TIMEOUT_CYC - 1) && !acc;
`else
  assign tmo_hit = 1'b0;
`endif
  assign legal = coin_val == 8'd1 || coin_val == 8'd2 || coin_val == 8'd5 || coin_val == 8'd10;
  assign sum = {1'b0, credit} + {1'b0, coin_val};
  assign acc = coin_valid && legal && sum <= 9'(CREDIT_MAX);
  assign new_credit = acc ? sum[7:0] : credit;
  assign quit = cancel || tmo_hit;
  assign den = credit >= 8'd10 ? 8'd10 : credit >= 8'd5 ? 8'd5 : credit >= 8'd2 ? 8'd2 : credit;
  assign coin_en = state == COLLECT;
  assign busy = state != IDLE;
  assign dispense = state == VEND;
  assign chg_valid = state == CHANGE && credit != 8'd0;
  always_comb begin
    chg_coin = 4'b0000;
    if (chg_valid)
      chg_coin = den == 8'd10 ? 4'b1000 : den == 8'd5 ? 4'b0100 : den == 8'd2 ? 4'b0010 : 4'b0001;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      credit <= 8'd0;
      price <= 8'd0;
      reject <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      timeout <= 1'b0;
      cnt <= '0;
`endif
    end else begin
      reject <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE:
          if (sel_valid && sel_price != 8'd0) begin
            price <= sel_price;
            credit <= 8'd0;
            state <= COLLECT;
`ifdef VEND_TIMEOUT_EN
            cnt <= '0;
`endif
          end
        COLLECT: begin
          reject <= coin_valid && !acc;
          credit <= new_credit;
`ifdef VEND_TIMEOUT_EN
          cnt <= acc ? '0 : cnt + 1'b1;
          timeout <= tmo_hit;
`endif
          // cancel outranks reaching the price; an empty timeout skips the refund
          if (quit) state <= (tmo_hit && !cancel && new_credit == 8'd0) ? IDLE : CHANGE;
          else if (new_credit >= price) state <= VEND;
        end
        VEND: begin
          credit <= credit - price;
          state <= credit != price ? CHANGE : IDLE;
        end
        default:
          if (credit == 8'd0) state <= IDLE;
          else if (chg_ack) begin
            credit <= credit - den;
            if (credit == den) state <= IDLE;
          end
      endcase
    end
endmodule

// File: tb/tb_vend_credit_ctrl.sv
// tb_vend_credit_ctrl: directed vectors for vend_credit_ctrl with hand-computed expectations.
module tb_vend_credit_ctrl;
  logic clk = 0, rst = 1;
  logic sel_valid = 0, coin_valid = 0, cancel = 0, chg_ack = 0;
  logic [7:0] sel_price = 0, coin_val = 0;
  logic coin_en, reject, dispense, chg_valid, busy;
  logic [7:0] credit;
  logic [3:0] chg_coin;
`ifdef VEND_TIMEOUT_EN
  logic timeout;
`endif
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  vend_credit_ctrl #(
    .CREDIT_MAX(99)
`ifdef VEND_TIMEOUT_EN
    , .TIMEOUT_CYC(16)
`endif
  ) dut (
    .clk(clk), .rst(rst), .sel_valid(sel_valid), .sel_price(sel_price),
    .coin_valid(coin_valid), .coin_val(coin_val), .cancel(cancel),
    .coin_en(coin_en), .credit(credit), .reject(reject), .dispense(dispense),
    .chg_valid(chg_valid), .chg_coin(chg_coin), .chg_ack(chg_ack), .busy(busy)
`ifdef VEND_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );
  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic sel(input logic [7:0] p);
    sel_valid = 1; sel_price = p; step; sel_valid = 0;
  endtask
  task automatic coin(input logic [7:0] v);
    coin_valid = 1; coin_val = v; step; coin_valid = 0;
  endtask
  logic [3:0] ec[3] = '{4'b0100, 4'b0010, 4'b0010};
  logic [7:0] cr[3] = '{8'd4, 8'd2, 8'd0};
  int n;
  initial begin
    #2;
    chk("rst_busy", busy, 0); chk("rst_credit", credit, 0); chk("rst_coin_en", coin_en, 0);
    chk("rst_chg_valid", chg_valid, 0); chk("rst_dispense", dispense, 0);
    step; rst = 0;
    sel(0);
    chk("sel0_ignored", busy, 0);
    // price 15, coins 10+10, ack tied high
    chg_ack = 1;
    sel(15);
    chk("t1_coin_en", coin_en, 1); chk("t1_credit0", credit, 0);
    coin(10);
    chk("t1_credit10", credit, 10); chk("t1_no_disp", dispense, 0);
    coin(10);
    chk("t1_credit20", credit, 20); chk("t1_disp", dispense, 1); chk("t1_no_chg", chg_valid, 0);
    step;
    chk("t1_disp_once", dispense, 0); chk("t1_chg_valid", chg_valid, 1);
    chk("t1_chg_coin", chg_coin, 4'b0100); chk("t1_change", credit, 5);
    step;
    chk("t1_done_valid", chg_valid, 0); chk("t1_idle", busy, 0);
    // price 8, exact credit 5+2+1
    sel(8); coin(5); coin(2); coin(1);
    chk("t2_disp", dispense, 1); chk("t2_chg", chg_valid, 0);
    step;
    chk("t2_idle", busy, 0); chk("t2_no_chg", chg_valid, 0); chk("t2_credit", credit, 0);
    // price 1, coin 10, slow hopper; inputs ignored during CHANGE
    chg_ack = 0;
    sel(1); coin(10);
    chk("t3_disp", dispense, 1);
    step;
    chk("t3_change", credit, 9);
    coin_valid = 1; coin_val = 3; cancel = 1; step; coin_valid = 0; cancel = 0;
    chk("t3_no_reject", reject, 0); chk("t3_held_credit", credit, 9);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 5; j++) begin
        chk("t3_hold_valid", chg_valid, 1); chk("t3_hold_coin", chg_coin, ec[i]);
        step;
      end
      chg_ack = 1; step; chg_ack = 0;
      chk("t3_credit", credit, cr[i]);
    end
    chk("t3_idle", busy, 0);
    // price 20, coin 5, cancel
    sel(20); coin(5);
    cancel = 1; step; cancel = 0;
    chk("t4_no_disp", dispense, 0); chk("t4_refund", credit, 5); chk("t4_coin", chg_coin, 4'b0100);
    chg_ack = 1; step;
    chk("t4_idle", busy, 0);
    // cancel with a price-reaching coin: refund wins
    chg_ack = 0;
    sel(15); coin(5);
    coin_valid = 1; coin_val = 10; cancel = 1; step; coin_valid = 0; cancel = 0;
    chk("t4b_no_disp", dispense, 0); chk("t4b_refund", credit, 15); chk("t4b_coin10", chg_coin, 4'b1000);
    chg_ack = 1; step;
    chk("t4b_coin5", chg_coin, 4'b0100); chk("t4b_rem", credit, 5);
    step;
    chk("t4b_idle", busy, 0); chk("t4b_valid_low", chg_valid, 0);
    // illegal coin and credit ceiling
    chg_ack = 0;
    sel(99); coin(3);
    chk("t5_reject", reject, 1); chk("t5_credit", credit, 0);
    step;
    chk("t5_reject_pulse", reject, 0);
    for (int i = 0; i < 9; i++) coin(10);
    coin(5);
    chk("t6_credit95", credit, 95); chk("t6_no_reject", reject, 0);
    coin(10);
    chk("t6_reject", reject, 1); chk("t6_credit_kept", credit, 95); chk("t6_still_collect", coin_en, 1);
    cancel = 1; step; cancel = 0;
    chg_ack = 1; n = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      if (chg_valid) n++;
      step;
    end
    chk("t6_transfers", n, 10); chk("t6_idle", busy, 0);
    // async reset during CHANGE
    chg_ack = 0;
    sel(5); coin(10); step;
    chk("t7_in_change", chg_valid, 1);
    #2 rst = 1; #1;
    chk("t7_busy", busy, 0); chk("t7_credit", credit, 0); chk("t7_chg_valid", chg_valid, 0);
    chk("t7_chg_coin", chg_coin, 0); chk("t7_coin_en", coin_en, 0);
    step; rst = 0; step;
    chk("t7_idle_after", busy, 0);
`ifdef VEND_TIMEOUT_EN
    sel(20); coin(2);
    for (int i = 0; i < 15; i++) begin
      chk("t8_no_timeout", timeout, 0);
      step;
    end
    chk("t8_still_collect", coin_en, 1);
    step;
    chk("t8_timeout", timeout, 1); chk("t8_refund", chg_coin, 4'b0010); chk("t8_credit", credit, 2);
    chg_ack = 1; step;
    chk("t8_timeout_pulse", timeout, 0); chk("t8_idle", busy, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
